// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, FSM state encoding and the nibble-wide
// reflected CRC-32 step used by both transmit and receive paths.
package eth_pkg;

  localparam int unsigned DEF_PREAMBLE_NIBBLES = 15;
  localparam int unsigned DEF_MIN_DATA_BYTES   = 60;
  localparam int unsigned DEF_IFG_NIBBLES      = 24;

  localparam int unsigned STATE_W = 4;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_PREAMBLE = 4'd1;
  localparam state_t ST_SFD      = 4'd2;
  localparam state_t ST_DATA_LO  = 4'd3;
  localparam state_t ST_DATA_HI  = 4'd4;
  localparam state_t ST_PAD_LO   = 4'd5;
  localparam state_t ST_PAD_HI   = 4'd6;
  localparam state_t ST_FCS      = 4'd7;
  localparam state_t ST_IFG      = 4'd8;
  localparam state_t ST_DRAIN    = 4'd9;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;

  // One nibble of the reflected CRC, bit 0 of the nibble goes on the wire first.
  function automatic logic [31:0] crc32_nibble(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nib[i]) c = (c >> 1) ^ CRC_POLY;
      else               c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d4.sv
// Combinational next-CRC for one MII nibble; the CRC register lives in the user.
module eth_crc32_d4
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  data,
  output logic [31:0] crc_next_c
);

  assign crc_next_c = crc32_nibble(crc, data);

endmodule

// File: rtl/mii_tx_framer.sv
// MII transmit framer: byte stream in, preamble/SFD/data/pad/FCS nibbles out,
// followed by the inter-frame gap. Underruns abort the frame and drain input.
module mii_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned PREAMBLE_NIBBLES = DEF_PREAMBLE_NIBBLES,
  parameter int unsigned MIN_DATA_BYTES   = DEF_MIN_DATA_BYTES,
  parameter int unsigned IFG_NIBBLES      = DEF_IFG_NIBBLES
) (
  input  logic       tx_clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [3:0] tx_data,
  output logic       tx_en,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BCNT_W = 11;
  localparam logic [BCNT_W-1:0] BCNT_MAX = '1;

  state_t              state_q, state_d;
  logic [3:0]          tx_data_d;
  logic                tx_en_d, in_ready_d, underrun_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [31:0]         crc_q, crc_d;
  logic [7:0]          byte_q, byte_d;
  logic                last_q, last_d;

  logic [3:0]          crc_nib_c;
  logic [31:0]         crc_next_c;
  logic [31:0]         fcs_c;
  logic [2:0]          fcs_idx_c;
  logic                short_c;
  logic [BCNT_W-1:0]   bcnt_inc_c;

  assign fcs_c      = ~crc_q;
  assign fcs_idx_c  = 3'(cnt_q + CNT_W'(1));
  assign short_c    = bcnt_q < BCNT_W'(MIN_DATA_BYTES);
  assign bcnt_inc_c = (bcnt_q == BCNT_MAX) ? bcnt_q : bcnt_q + BCNT_W'(1);

  // Nibble entering the CRC on the transition out of the current state.
  always_comb begin
    crc_nib_c = 4'h0;
    case (state_q)
      ST_SFD:     crc_nib_c = in_data[3:0];
      ST_DATA_HI: if (in_ready) crc_nib_c = in_data[3:0];
      ST_DATA_LO: crc_nib_c = byte_q[7:4];
      default:    crc_nib_c = 4'h0;
    endcase
  end

  eth_crc32_d4 u_crc (
    .crc        (crc_q),
    .data       (crc_nib_c),
    .crc_next_c (crc_next_c)
  );

  // Next state plus the values every registered output takes with it.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = 4'h0;
    tx_en_d    = 1'b0;
    in_ready_d = 1'b0;
    underrun_d = 1'b0;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    crc_d      = crc_q;
    byte_d     = byte_q;
    last_d     = last_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_PREAMBLE;
          tx_en_d   = 1'b1;
          tx_data_d = PREAMBLE_NIB;
          cnt_d     = '0;
        end
      end

      ST_PREAMBLE: begin
        tx_en_d = 1'b1;
        if (cnt_q == CNT_W'(PREAMBLE_NIBBLES - 1)) begin
          state_d    = ST_SFD;
          tx_data_d  = SFD_NIB;
          in_ready_d = 1'b1;
          crc_d      = CRC_INIT;
          bcnt_d     = '0;
          last_d     = 1'b0;
        end else begin
          tx_data_d = PREAMBLE_NIB;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      // Byte boundary: capture the next byte, underrun, or finish with pad/FCS.
      ST_SFD, ST_DATA_HI, ST_PAD_HI: begin
        if (in_ready && !in_valid) begin
          state_d    = ST_DRAIN;
          in_ready_d = 1'b1;
          underrun_d = 1'b1;
        end else if (in_ready) begin
          state_d   = ST_DATA_LO;
          tx_en_d   = 1'b1;
          tx_data_d = in_data[3:0];
          byte_d    = in_data;
          last_d    = in_last;
          crc_d     = crc_next_c;
        end else if (short_c) begin
          state_d   = ST_PAD_LO;
          tx_en_d   = 1'b1;
          tx_data_d = 4'h0;
          crc_d     = crc_next_c;
        end else begin
          state_d   = ST_FCS;
          tx_en_d   = 1'b1;
          tx_data_d = fcs_c[3:0];
          cnt_d     = '0;
        end
      end

      ST_DATA_LO: begin
        state_d    = ST_DATA_HI;
        tx_en_d    = 1'b1;
        tx_data_d  = byte_q[7:4];
        crc_d      = crc_next_c;
        bcnt_d     = bcnt_inc_c;
        in_ready_d = !last_q;
      end

      ST_PAD_LO: begin
        state_d   = ST_PAD_HI;
        tx_en_d   = 1'b1;
        tx_data_d = 4'h0;
        crc_d     = crc_next_c;
        bcnt_d    = bcnt_inc_c;
      end

      ST_FCS: begin
        if (cnt_q == CNT_W'(7)) begin
          state_d = ST_IFG;
          cnt_d   = '0;
        end else begin
          tx_en_d   = 1'b1;
          tx_data_d = fcs_c[{fcs_idx_c, 2'b00} +: 4];
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      ST_IFG: begin
        if (cnt_q == CNT_W'(IFG_NIBBLES - 1)) state_d = ST_IDLE;
        else                                   cnt_d   = cnt_q + CNT_W'(1);
      end

      // Swallow the rest of an aborted packet without transmitting it.
      ST_DRAIN: begin
        in_ready_d = 1'b1;
        if (in_valid && in_last) begin
          state_d    = ST_IFG;
          in_ready_d = 1'b0;
          cnt_d      = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tx_data  <= 4'h0;
      tx_en    <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      crc_q    <= CRC_INIT;
      byte_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_data  <= tx_data_d;
      tx_en    <= tx_en_d;
      in_ready <= in_ready_d;
      busy     <= (state_d != ST_IDLE);
      underrun <= underrun_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      crc_q    <= crc_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Directed-sequence bench with random payloads; frames captured off the MII bus
// are compared against a byte-level Ethernet framing model.
module tb_mii_tx_framer;

  typedef logic [7:0] bq_t[$];
  typedef logic [3:0] nq_t[$];

  localparam int MIN_BYTES = 60;

  logic       tx_clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [3:0] tx_data;
  logic       tx_en;
  logic       busy;
  logic       underrun;

  int n_tests = 0;
  int n_fail  = 0;

  mii_tx_framer dut (
    .tx_clk   (tx_clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .busy     (busy),
    .underrun (underrun)
  );

  always #20 tx_clk = ~tx_clk;

  // Bus monitor: frames are runs of tx_en high; partial frames cut by reset are dropped.
  logic [3:0] nib_q[$];
  logic [3:0] cur_q[$];
  int frame_off[$];
  int frame_len[$];
  int frame_gap[$];
  int cur_len = 0, cur_gap = 0, low_cnt = 0;
  bit in_frame = 1'b0, prev_en = 1'b0, prev_rdy = 1'b0;
  int ur_cnt = 0, ur_aligned = 0, rdy_idle = 0, rdy_back = 0;

  always @(negedge tx_clk) begin
    if (!rst_n) begin
      cur_q.delete();
      in_frame <= 1'b0;
      cur_len  <= 0;
      low_cnt  <= 0;
      prev_en  <= 1'b0;
      prev_rdy <= 1'b0;
    end else begin
      if (tx_en) begin
        if (!in_frame) begin
          in_frame <= 1'b1;
          cur_gap  <= low_cnt;
          cur_len  <= 1;
        end else begin
          cur_len <= cur_len + 1;
        end
        cur_q.push_back(tx_data);
      end else begin
        if (in_frame) begin
          frame_off.push_back(nib_q.size());
          frame_len.push_back(cur_len);
          frame_gap.push_back(cur_gap);
          foreach (cur_q[i]) nib_q.push_back(cur_q[i]);
          cur_q.delete();
          in_frame <= 1'b0;
          low_cnt  <= 1;
        end else begin
          low_cnt <= low_cnt + 1;
        end
      end
      if (underrun) begin
        ur_cnt <= ur_cnt + 1;
        if (prev_en && !tx_en) ur_aligned <= ur_aligned + 1;
      end
      if (in_ready && !busy) rdy_idle <= rdy_idle + 1;
      if (in_ready && prev_rdy && tx_en && prev_en) rdy_back <= rdy_back + 1;
      prev_en  <= tx_en;
      prev_rdy <= in_ready;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference CRC-32: bytes sent least significant bit first, reflected poly.
  function automatic logic [31:0] crc_bytes(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ b[i][k]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic nq_t exp_nibbles(input bq_t b);
    nq_t e;
    bq_t p;
    logic [31:0] f;
    p = b;
    while (p.size() < MIN_BYTES) p.push_back(8'h00);
    repeat (15) e.push_back(4'h5);
    e.push_back(4'hD);
    foreach (p[i]) begin
      e.push_back(p[i][3:0]);
      e.push_back(p[i][7:4]);
    end
    f = ~crc_bytes(p);
    for (int i = 0; i < 8; i++) e.push_back(f[4*i +: 4]);
    return e;
  endfunction

  task automatic check_frame(input int k, input bq_t b, input string tag);
    nq_t e;
    int off, len, m_pre, m_dat;
    logic [31:0] obs_fcs, exp_fcs, rc;
    logic bv;
    if (k >= frame_len.size()) begin
      check({tag, "_present"}, 32'(frame_len.size()), 32'(k + 1));
      return;
    end
    e   = exp_nibbles(b);
    off = frame_off[k];
    len = frame_len[k];
    check({tag, "_len"}, 32'(len), 32'(e.size()));
    m_pre = 0;
    for (int i = 0; i < 16; i++)
      if (i >= len || nib_q[off+i] !== e[i]) m_pre++;
    check({tag, "_preamble_sfd"}, 32'(m_pre), 32'd0);
    m_dat = 0;
    for (int i = 16; i < e.size() - 8; i++)
      if (i >= len || nib_q[off+i] !== e[i]) m_dat++;
    check({tag, "_payload_pad"}, 32'(m_dat), 32'd0);
    obs_fcs = '0;
    exp_fcs = '0;
    for (int i = 0; i < 8; i++) begin
      exp_fcs[4*i +: 4] = e[e.size() - 8 + i];
      if (len >= 8) obs_fcs[4*i +: 4] = nib_q[off + len - 8 + i];
    end
    check({tag, "_fcs"}, obs_fcs, exp_fcs);
    rc = 32'hFFFF_FFFF;
    for (int i = 16; i < len; i++) begin
      for (int j = 0; j < 4; j++) begin
        bv = nib_q[off+i][j];
        if (rc[0] ^ bv) rc = (rc >> 1) ^ 32'hEDB8_8320;
        else            rc = rc >> 1;
      end
    end
    check({tag, "_residue"}, rc, 32'hDEBB_20E3);
  endtask

  // Feeds a byte stream; in_last marks index n_first-1 and the final byte.
  task automatic drive_stream(input bq_t b, input int n_first, input int drop_at, input int drop_len);
    int i, cyc, dropped;
    bit acc;
    i = 0; cyc = 0; dropped = 0;
    @(negedge tx_clk);
    in_valid = 1'b1;
    in_data  = b[0];
    in_last  = (n_first == 1) || (b.size() == 1);
    while (i < b.size() && cyc < 5000) begin
      acc = in_valid && in_ready;
      @(negedge tx_clk);
      cyc++;
      if (acc) begin
        i++;
        if (i < b.size()) begin
          in_data = b[i];
          in_last = (i == n_first - 1) || (i == b.size() - 1);
        end
      end
      if (drop_at >= 0 && i == drop_at && dropped < drop_len) begin
        in_valid = 1'b0;
        dropped++;
      end else begin
        in_valid = (i < b.size());
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bytes_consumed", 32'(i), 32'(b.size()));
  endtask

  task automatic wait_frames(input int n);
    int c;
    c = 0;
    while (frame_len.size() < n && c < 4000) begin
      @(posedge tx_clk);
      c++;
    end
    repeat (2) @(posedge tx_clk);
    check($sformatf("frame_count_%0d", n), 32'(frame_len.size()), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_en"},    32'(tx_en),    32'd0);
    check({tag, "_tx_data"},  32'(tx_data),  32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f0, f1, f2, f3, f4, f5, f6, f7, f8, s;
    nq_t e;
    int m, c;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    #30;
    check_reset_outputs("reset");
    repeat (2) @(negedge tx_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge tx_clk);

    // Exactly minimum length, valid held high.
    f0 = rand_bytes(60);
    drive_stream(f0, 60, -1, 0);
    wait_frames(1);
    check_frame(0, f0, "f60");

    // Short frame padded with 46 zero bytes.
    f1 = rand_bytes(14);
    drive_stream(f1, 14, -1, 0);
    wait_frames(2);
    check_frame(1, f1, "f14");

    // Back-to-back 100-byte frames.
    f2 = rand_bytes(100);
    f3 = rand_bytes(100);
    s  = {f2, f3};
    drive_stream(s, 100, -1, 0);
    wait_frames(4);
    check_frame(2, f2, "b2b_a");
    check_frame(3, f3, "b2b_b");
    check("b2b_gap", 32'(frame_gap[3]), 32'd25);

    // Random length.
    f4 = rand_bytes(int'($urandom_range(1, 90)));
    drive_stream(f4, f4.size(), -1, 0);
    wait_frames(5);
    check_frame(4, f4, "frand");

    // Underrun after 20 of 64 bytes, next frame queued right behind it.
    f5 = rand_bytes(64);
    f6 = rand_bytes(30);
    s  = {f5, f6};
    drive_stream(s, 64, 20, 4);
    wait_frames(7);
    check("underrun_pulses", 32'(ur_cnt), 32'd1);
    check("underrun_with_txen_fall", 32'(ur_aligned), 32'd1);
    check("aborted_len", 32'(frame_len[5]), 32'd56);
    e = exp_nibbles(f5);
    m = 0;
    for (int i = 0; i < 56; i++)
      if (nib_q[frame_off[5] + i] !== e[i]) m++;
    check("aborted_content", 32'(m), 32'd0);
    check("after_underrun_gap_ok", 32'(frame_gap[6] >= 25), 32'd1);
    check_frame(6, f6, "after_ur");

    // Reset asserted in the middle of the FCS.
    f7 = rand_bytes(60);
    drive_stream(f7, 60, -1, 0);
    c = 0;
    while (cur_len != 139 && c < 2000) begin
      @(posedge tx_clk);
      c++;
    end
    check("reached_fcs", 32'(cur_len), 32'd139);
    #5 rst_n = 1'b0;
    #1 check_reset_outputs("mid_fcs_reset");
    repeat (2) @(negedge tx_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge tx_clk);
    check("no_frame_from_reset", 32'(frame_len.size()), 32'd7);
    f8 = rand_bytes(30);
    drive_stream(f8, 30, -1, 0);
    wait_frames(8);
    check_frame(7, f8, "post_reset");

    check("in_ready_in_idle", 32'(rdy_idle), 32'd0);
    check("in_ready_back_to_back", 32'(rdy_back), 32'd0);
    check("underrun_total", 32'(ur_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
